// File: rtl/register_bank_pkg.sv
// register_bank_pkg
// Shared constants and helpers for the register bank slice.
//   DEFAULT_WIDTH : default data bits per register
//   DEFAULT_DEPTH : default number of registers
//   clog2()       : ceiling log2, minimum result 1, for address widths
package register_bank_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 32;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/register_bank_cell.sv
// register_bank_cell
// One WIDTH-bit storage register of the bank.
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset, zeroes q
//   clear in  synchronous clear, priority over en
//   en    in  load enable
//   d     in  WIDTH  load data
//   q     out WIDTH  stored value
module register_bank_cell
    import register_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_bank.sv
// register_bank
// DEPTH x WIDTH register file with two combinational read ports and a busy
// (outstanding producer) bit per register.
// Optional feature: define REGISTER_BANK_BYPASS_EN to forward the write data
// (and the resulting busy state) to a read port addressing the register being
// written in the same cycle.
// Ports:
//   clk       in  rising-edge clock
//   rst_n     in  asynchronous active-low reset
//   clear     in  synchronous clear of all data and busy bits
//   we        in  write enable
//   waddr     in  AW     write address
//   wdata     in  WIDTH  write data
//   raddr_a   in  AW     read port A address
//   rdata_a   out WIDTH  read port A data
//   raddr_b   in  AW     read port B address
//   rdata_b   out WIDTH  read port B data
//   busy_set  in  mark busy_addr busy
//   busy_addr in  AW     register to mark busy
//   busy_a    out busy bit of raddr_a
//   busy_b    out busy bit of raddr_b
module register_bank
    import register_bank_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             busy_set,
    input  logic [AW-1:0]    busy_addr,
    output logic             busy_a,
    output logic             busy_b
);

    // Storage spans the full address space; entries that are out of range or
    // hardwired to zero are constant 0, so reads need no range check.
    localparam int unsigned NR = 1 << AW;

    logic [WIDTH-1:0] regs [NR];
    logic [NR-1:0]    busy_q;
    logic [NR-1:0]    busy_next;
    logic             wr_ok;
    logic             bs_ok;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok = we && addr_ok(waddr);
    assign bs_ok = busy_set && addr_ok(busy_addr);

    for (genvar i = 0; i < NR; i++) begin : g_reg
        if ((i >= int'(DEPTH)) || ((ZERO_REG != 0) && (i == 0))) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_cell
            register_bank_cell #(.WIDTH(WIDTH)) u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .clear (clear),
                .en    (wr_ok && (waddr == AW'(i))),
                .d     (wdata),
                .q     (regs[i])
            );
        end
    end

    // busy_set is applied after the write-clear so a new producer wins.
    always_comb begin
        busy_next = busy_q;
        for (int unsigned i = 0; i < NR; i++) begin
            if (wr_ok && (32'(waddr) == i))     busy_next[i] = 1'b0;
            if (bs_ok && (32'(busy_addr) == i)) busy_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else if (clear) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

`ifdef REGISTER_BANK_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    // Forwarding is suppressed in reset and on clear, when no write lands.
    assign fwd_a = rst_n && !clear && wr_ok && (waddr == raddr_a);
    assign fwd_b = rst_n && !clear && wr_ok && (waddr == raddr_b);

    always_comb begin
        rdata_a = fwd_a ? wdata : regs[raddr_a];
        rdata_b = fwd_b ? wdata : regs[raddr_b];
        busy_a  = fwd_a ? (bs_ok && (busy_addr == raddr_a)) : busy_q[raddr_a];
        busy_b  = fwd_b ? (bs_ok && (busy_addr == raddr_b)) : busy_q[raddr_b];
    end
`else
    always_comb begin
        rdata_a = regs[raddr_a];
        rdata_b = regs[raddr_b];
        busy_a  = busy_q[raddr_a];
        busy_b  = busy_q[raddr_b];
    end
`endif

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

`ifdef REGISTER_BANK_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        clear;

    // Default-sized instance
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [31:0] rdata_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_b;
    logic        busy_set;
    logic [4:0]  busy_addr;
    logic        busy_a;
    logic        busy_b;

    // DEPTH=24, WIDTH=8 instance
    logic        s_we;
    logic [4:0]  s_waddr;
    logic [7:0]  s_wdata;
    logic [4:0]  s_raddr_a;
    logic [7:0]  s_rdata_a;
    logic [4:0]  s_raddr_b;
    logic [7:0]  s_rdata_b;
    logic        s_busy_set;
    logic [4:0]  s_busy_addr;
    logic        s_busy_a;
    logic        s_busy_b;

    register_bank dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr_a   (raddr_a),
        .rdata_a   (rdata_a),
        .raddr_b   (raddr_b),
        .rdata_b   (rdata_b),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .busy_a    (busy_a),
        .busy_b    (busy_b)
    );

    register_bank #(.WIDTH(8), .DEPTH(24), .ZERO_REG(1)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .we        (s_we),
        .waddr     (s_waddr),
        .wdata     (s_wdata),
        .raddr_a   (s_raddr_a),
        .rdata_a   (s_rdata_a),
        .raddr_b   (s_raddr_b),
        .rdata_b   (s_rdata_b),
        .busy_set  (s_busy_set),
        .busy_addr (s_busy_addr),
        .busy_a    (s_busy_a),
        .busy_b    (s_busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int unsigned RA = 0, RB = 1, BA = 2, BB = 3;
    localparam int unsigned SRA = 4, SRB = 5, SBA = 6, SBB = 7;

    typedef struct {
        string       tag;
        int unsigned sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q [$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int unsigned sel);
        case (sel)
            RA:      return rdata_a;
            RB:      return rdata_b;
            BA:      return {31'd0, busy_a};
            BB:      return {31'd0, busy_b};
            SRA:     return {24'd0, s_rdata_a};
            SRB:     return {24'd0, s_rdata_b};
            SBA:     return {31'd0, s_busy_a};
            default: return {31'd0, s_busy_b};
        endcase
    endfunction

    task automatic expect_out(input string tag, input int unsigned sel, input logic [31:0] exp);
        exp_q.push_back('{tag, sel, exp});
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        busy_set = 1'b0; busy_addr = '0;
        s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_raddr_a = '0; s_raddr_b = '0;
        s_busy_set = 1'b0; s_busy_addr = '0;

        // Outputs while in reset
        raddr_a = 5'd5; raddr_b = 5'd7;
        #3;
        expect_out("rst_rdata_a", RA, 32'h0);
        expect_out("rst_busy_a",  BA, 32'h0);
        expect_out("rst_rdata_b", RB, 32'h0);
        expect_out("rst_s_rdata_a", SRA, 32'h0);
        drain();
        tick();
        rst_n = 1'b1;

        // Write reg5, then async reset mid-cycle wipes it
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        we = 1'b0;
        #2;
        expect_out("wr5_rdata_a", RA, 32'hDEADBEEF);
        drain();
        rst_n = 1'b0;
        #1;
        expect_out("async_rst_rdata_a", RA, 32'h0);
        drain();
        tick();
        rst_n = 1'b1;

        // Write 7, read on both ports same cycle and next cycle
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; raddr_a = 5'd7; raddr_b = 5'd7;
        #2;
        expect_out("wr7_same_a", RA, BYP ? 32'h12345678 : 32'h0);
        expect_out("wr7_same_b", RB, BYP ? 32'h12345678 : 32'h0);
        drain();
        tick();
        we = 1'b0;
        #2;
        expect_out("wr7_next_a", RA, 32'h12345678);
        expect_out("wr7_next_b", RB, 32'h12345678);
        drain();

        // Register 0 is hardwired
        tick();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; busy_set = 1'b1; busy_addr = 5'd0;
        raddr_a = 5'd0;
        #2;
        expect_out("zero_same_rdata", RA, 32'h0);
        expect_out("zero_same_busy",  BA, 32'h0);
        drain();
        tick();
        we = 1'b0; busy_set = 1'b0;
        #2;
        expect_out("zero_rdata", RA, 32'h0);
        expect_out("zero_busy",  BA, 32'h0);
        drain();

        // Busy scoreboard on register 3
        tick();
        busy_set = 1'b1; busy_addr = 5'd3; raddr_a = 5'd3; raddr_b = 5'd4;
        tick();
        busy_set = 1'b0;
        #2;
        expect_out("busy3_set",   BA, 32'h1);
        expect_out("busy4_clean", BB, 32'h0);
        drain();
        tick();
        we = 1'b1; waddr = 5'd3; wdata = 32'h33;
        #2;
        expect_out("busy3_wr_same",  BA, BYP ? 32'h0 : 32'h1);
        expect_out("rd3_wr_same",    RA, BYP ? 32'h33 : 32'h0);
        drain();
        tick();
        we = 1'b0;
        #2;
        expect_out("busy3_cleared", BA, 32'h0);
        expect_out("rd3_written",   RA, 32'h33);
        drain();
        tick();
        we = 1'b1; waddr = 5'd3; wdata = 32'h44; busy_set = 1'b1; busy_addr = 5'd3;
        #2;
        expect_out("busy3_both_same", BA, BYP ? 32'h1 : 32'h0);
        drain();
        tick();
        we = 1'b0; busy_set = 1'b0; raddr_b = 5'd3;
        #2;
        expect_out("busy3_both_a", BA, 32'h1);
        expect_out("busy3_both_b", BB, 32'h1);
        expect_out("rd3_both",     RA, 32'h44);
        drain();

        // Clear has priority over write and busy_set
        tick();
        we = 1'b1; waddr = 5'd9; wdata = 32'h77; busy_set = 1'b1; busy_addr = 5'd10;
        tick();
        we = 1'b0; busy_set = 1'b0; raddr_a = 5'd9; raddr_b = 5'd10;
        #2;
        expect_out("pre_clr_rd9",   RA, 32'h77);
        expect_out("pre_clr_busy10", BB, 32'h1);
        drain();
        tick();
        clear = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'hA5; busy_set = 1'b1; busy_addr = 5'd11;
        tick();
        clear = 1'b0; we = 1'b0; busy_set = 1'b0;
        #2;
        expect_out("clr_rd9",    RA, 32'h0);
        expect_out("clr_busy10", BB, 32'h0);
        drain();
        raddr_a = 5'd3; raddr_b = 5'd11;
        #1;
        expect_out("clr_busy3",  BA, 32'h0);
        expect_out("clr_rd3",    RA, 32'h0);
        expect_out("clr_busy11", BB, 32'h0);
        drain();
        raddr_a = 5'd7;
        #1;
        expect_out("clr_rd7", RA, 32'h0);
        drain();

        // Non-power-of-2 depth: out-of-range addresses
        tick();
        s_we = 1'b1; s_waddr = 5'd23; s_wdata = 8'h5C;
        tick();
        s_we = 1'b1; s_waddr = 5'd30; s_wdata = 8'hAB; s_busy_set = 1'b1; s_busy_addr = 5'd30;
        s_raddr_a = 5'd30; s_raddr_b = 5'd23;
        tick();
        s_we = 1'b0; s_busy_set = 1'b0;
        #2;
        expect_out("s_rd30",   SRA, 32'h0);
        expect_out("s_busy30", SBA, 32'h0);
        expect_out("s_rd23",   SRB, 32'h5C);
        expect_out("s_busy23", SBB, 32'h0);
        drain();
        s_raddr_a = 5'd0; s_raddr_b = 5'd14;
        #1;
        expect_out("s_rd0",  SRA, 32'h0);
        expect_out("s_rd14", SRB, 32'h0);
        drain();

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL take parameter WIDTH, default 32: data bits per register.
REQ-002 SHALL take parameter DEPTH, default 32: number of registers, 2..64.
REQ-003 SHALL take parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-004 SHALL derive localparam AW = clog2(DEPTH): address width.
REQ-005 Ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge; all state updates on it.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous clear of all registers and busy bits.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddr_a  in  AW  read port A address.
- rdata_a  out  WIDTH  read port A data.
- raddr_b  in  AW  read port B address.
- rdata_b  out  WIDTH  read port B data.
- busy_set  in  1  mark busy_addr as having an outstanding producer.
- busy_addr  in  AW  register to mark busy.
- busy_a  out  1  busy bit of raddr_a.
- busy_b  out  1  busy bit of raddr_b.

Function
REQ-006 SHALL hold DEPTH x WIDTH data registers and DEPTH busy bits.
REQ-007 SHALL load wdata into register waddr at the rising edge when we=1 and clear=0; unwritten registers hold.
REQ-008 SHALL provide combinational reads: rdata_x = reg[raddr_x], and busy_x = busy[raddr_x], in the same cycle.
REQ-009 SHALL drive rdata_x and busy_x to 0 when raddr_x >= DEPTH (non-power-of-2 DEPTH).
REQ-010 SHALL ignore writes and busy_set to addresses >= DEPTH.
REQ-011 With ZERO_REG=1: SHALL ignore writes and busy_set to address 0; reads of address 0 return 0 and busy 0.
REQ-012 SHALL set busy[busy_addr] at the edge when busy_set=1.
REQ-013 SHALL clear busy[waddr] at the edge when we=1.
REQ-014 When busy_set and we target the same address in one cycle: SHALL set the busy bit; a new producer wins. The data write still occurs.
REQ-015 When clear=1: SHALL zero all data and busy bits at that edge. clear has priority over we and busy_set.
REQ-016 Both read ports SHALL be independent; they may use the same address.

Reset
REQ-017 When rst_n=0: SHALL immediately zero all data registers and busy bits, with no clock required.
REQ-018 While rst_n=0: all outputs SHALL read 0.
REQ-019 On rst_n deassertion: SHALL accept the first write at the next rising edge.

Configuration
REQ-020 Macro REGISTER_BANK_BYPASS_EN SHALL control write-to-read forwarding.
- Defined: when we=1 and waddr equals raddr_x (valid, not hardwired 0), rdata_x SHALL be wdata in the same cycle, and busy_x SHALL be 0 unless busy_set also targets that address.
- Undefined: reads SHALL return the pre-edge stored value. The write is visible the cycle after the edge.

Structure
REQ-021 SHALL place the shared constants DEFAULT_WIDTH=32 and DEFAULT_DEPTH=32, and the clog2 helper function, in package register_bank_pkg.
REQ-022 SHALL use one sub-module, register_bank_cell: a WIDTH-bit register with async active-low reset, sync clear and enable. It is instantiated DEPTH times, omitting index 0 when ZERO_REG=1.

Verification
REQ-023 Reset: rst_n=0 mid-cycle after writing reg5=0xDEADBEEF -> rdata_a(raddr_a=5)=0 immediately, with no clock edge.
REQ-024 Write/read: we=1, waddr=7, wdata=0x12345678, then raddr_a=7 and raddr_b=7 next cycle -> both ports read 0x12345678. Same cycle: 0 without bypass, 0x12345678 with REGISTER_BANK_BYPASS_EN.
REQ-025 Zero register: we=1, waddr=0, wdata=0xFFFFFFFF and busy_set=1, busy_addr=0 -> rdata_a(0)=0, busy_a=0.
REQ-026 Scoreboard: busy_set, busy_addr=3 -> busy_a(3)=1 next cycle. Then we=1, waddr=3 -> busy_a=0. Same-cycle busy_set and we on 3 -> busy_a stays 1.
REQ-027 Clear priority: clear=1 with we=1, waddr=9, wdata=0xA5 -> reg9=0 and all busy bits 0.
REQ-028 DEPTH=24, WIDTH=8: we to address 30 -> no register changes; raddr_a=30 -> rdata_a=0, busy_a=0.
